rv_mem_arbiter: RTL and testbench
=================================

# rv_mem_arbiter

Shares one single-ported unified memory between the instruction-fetch stage and the data-memory (MEM) stage of the pipelined RV32 core. Runs a small FSM that accepts one request at a time, drives the memory handshake and returns the response to the winning requester with a one-cycle ready pulse. Data accesses have priority, with a bounded-starvation rule for fetch. Sits between the core's IF/MEM stages and the memory model used by the system testbench.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 wide)
- MAX_DATA_BURST, 4, maximum number of consecutive data grants while a fetch is waiting; must be ≥1
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- if_req  input  1  fetch request; held with if_addr stable until if_ready
- if_addr  input  AW  fetch address
- if_rdata  output  DW  fetched word, valid while if_ready=1 and held afterwards
- if_ready  output  1  one-cycle completion pulse to fetch
- d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_ready
- d_we  input  1  1 = store, 0 = load
- d_addr  input  AW  data address
- d_wdata  input  DW  store data
- d_be  input  DW/8  store byte enables
- d_rdata  output  DW  load data, valid while d_ready=1 and held afterwards
- d_ready  output  1  one-cycle completion pulse to MEM stage
- mem_req  output  1  memory request; held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_be  output  DW/8  memory byte enables
- mem_rdata  input  DW  memory read data, valid in the mem_ack cycle
- mem_ack  input  1  one-cycle completion from memory; any latency ≥0 cycles after mem_req rises
- arb_busy  output  1  1 whenever state ≠ IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE: if neither request is asserted, stay. Otherwise pick a winner, register the mem_* fields, go to BUSY_I or BUSY_D.
- Fetch fields: mem_we=0, mem_be=all ones, mem_wdata=0.
- Data fields: taken from d_we, d_addr, d_wdata, d_be.
- Arbitration:
  - only one request present: it wins.
  - both present: data wins unless streak == MAX_DATA_BURST, in which case fetch wins.
- streak counter (width $clog2(MAX_DATA_BURST+1)):
  - +1 on a data grant while if_req=1, saturating.
  - cleared on any fetch grant, and on a data grant while if_req=0.
- BUSY_x: mem_req=1 and mem_* fields stable. On mem_ack, go to RESP_x.
  - BUSY_I: capture mem_rdata into if_rdata.
  - BUSY_D, load: capture mem_rdata into d_rdata.
  - BUSY_D, store: d_rdata unchanged.
- RESP_x: x_ready=1 for exactly this cycle, mem_req=0, requests ignored. Next state is IDLE.
- mem_ack in IDLE or RESP_x: ignored.
- Requesters must deassert req or present a new request in the cycle after ready. A req still high in IDLE is treated as a new request.
- Reset, including mid-transaction: state=IDLE, streak=0, all outputs 0 (if_rdata, d_rdata, mem_addr, mem_wdata, mem_be, mem_we, mem_req, if_ready, d_ready, arb_busy). Any outstanding memory access is abandoned; a late mem_ack is ignored.

## Timing
- Cycle 0: request sampled in IDLE.
- Cycle 1: mem_req=1.
- Cycle 1+L: mem_ack, where L ≥ 0 is the memory latency.
- Cycle 2+L: x_ready=1.
- Cycle 3+L: back in IDLE; the next request can be sampled.
- Minimum turnaround is 3 cycles per access; throughput is one access per 3+L cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Grant decision depends only on the request values and streak in the IDLE cycle.
- A request arriving during BUSY/RESP waits; no request is lost, because requesters hold req until ready.

## Test plan
- Fetch only, if_addr=0x100, mem_rdata=0x00500093, L=0:
  - mem_req at cycle 1 with mem_addr=0x100, mem_we=0, mem_be=0xF.
  - if_ready at cycle 2 with if_rdata=0x00500093.
- Store d_addr=0x200, d_wdata=0xDEADBEEF, d_be=0x3, L=3:
  - mem_we=1, mem_be=0x3 held for 4 cycles.
  - d_ready at cycle 5; d_rdata keeps its previous value.
- Both requests held continuously, MAX_DATA_BURST=4, each access completing normally:
  - grant order D,D,D,D,I,D,D,D,D,I.
  - exactly one if_ready per 5 grants.
- Fetch request arrives while a data load is in BUSY_D:
  - the load completes with d_ready first.
  - the fetch is granted in the following IDLE cycle.
- rst asserted in BUSY_D, then released; memory then raises mem_ack:
  - all outputs 0 and state IDLE immediately.
  - no ready pulse follows; the stray mem_ack is ignored.
- mem_ack pulsed while in IDLE with no requests: no state change, no ready pulse.

Source files
------------

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one single-ported memory between fetch and data with data priority and bounded fetch starvation
module rv_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            arb_busy
);
  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;
  state_t state;
  logic [SW-1:0] streak;
  logic fetch_win;
  logic streak_max;
  always_comb begin
    streak_max = streak == SW'(MAX_DATA_BURST);
    fetch_win = if_req && (!d_req || streak_max);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      streak <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
      if_ready <= 1'b0;
      d_ready <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      arb_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (if_req || d_req) begin
          state <= fetch_win ? BUSY_I : BUSY_D;
          mem_req <= 1'b1;
          arb_busy <= 1'b1;
          mem_we <= !fetch_win && d_we;
          mem_addr <= fetch_win ? if_addr : d_addr;
          mem_wdata <= fetch_win ? '0 : d_wdata;
          mem_be <= fetch_win ? '1 : d_be;
          streak <= (fetch_win || !if_req) ? '0 : streak_max ? streak : streak + SW'(1);
        end
        BUSY_I: if (mem_ack) begin
          state <= RESP_I;
          mem_req <= 1'b0;
          if_ready <= 1'b1;
          if_rdata <= mem_rdata;
        end
        BUSY_D: if (mem_ack) begin
          state <= RESP_D;
          mem_req <= 1'b0;
          d_ready <= 1'b1;
          d_rdata <= mem_we ? d_rdata : mem_rdata;
        end
        default: begin
          state <= IDLE;
          if_ready <= 1'b0;
          d_ready <= 1'b0;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: scoreboard bench for the fetch/data memory arbiter
module tb_rv_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic if_ready;
  logic d_req = 1'b0;
  logic d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0] d_be = '0;
  logic [31:0] d_rdata;
  logic d_ready;
  logic mem_req;
  logic mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_be;
  logic [31:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic arb_busy;
  always #5 clk = ~clk;
  rv_mem_arbiter #(.AW(32), .DW(32), .MAX_DATA_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .arb_busy(arb_busy)
  );
  typedef struct {
    bit is_d;
    logic [31:0] addr;
    logic we;
    logic [3:0] be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int lat = 0;
  int cnt = 0;
  bit acked = 0;
  bit mem_en = 1;
  bit prev_req = 0;
  logic [31:0] d_model = '0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h100 ? 32'h00500093 : {~a[15:0], a[15:0]};
  endfunction
  task automatic push(input bit is_d, input logic [31:0] addr, input logic we, input logic [3:0] be, input logic [31:0] wdata);
    exp_t e;
    e.is_d = is_d;
    e.addr = addr;
    e.we = we;
    e.be = be;
    e.wdata = wdata;
    if (!is_d) e.rdata = mem_word(addr);
    else begin
      if (!we) d_model = mem_word(addr);
      e.rdata = d_model;
    end
    exp_q.push_back(e);
  endtask
  initial forever begin
    @(negedge clk);
    if (mem_en) begin
      mem_ack = 1'b0;
      if (rst || !mem_req) begin
        cnt = 0;
        acked = 0;
      end else if (!acked) begin
        if (cnt == lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_word(mem_addr);
          acked = 1;
        end else cnt++;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst && mem_req && !prev_req) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL grant: unexpected access addr=%h", mem_addr);
      end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {exp_q[0].we, exp_q[0].addr, exp_q[0].be, exp_q[0].wdata}) begin
        fails++;
        $display("FAIL grant: got we=%b addr=%h be=%h wdata=%h, want we=%b addr=%h be=%h wdata=%h",
                 mem_we, mem_addr, mem_be, mem_wdata, exp_q[0].we, exp_q[0].addr, exp_q[0].be, exp_q[0].wdata);
      end
    end
    if (if_ready || d_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL response: unexpected ready if=%b d=%b", if_ready, d_ready);
      end else begin
        exp_t e;
        logic [31:0] got;
        e = exp_q.pop_front();
        got = if_ready ? if_rdata : d_rdata;
        if ({d_ready, if_ready, got} !== {e.is_d, !e.is_d, e.rdata}) begin
          fails++;
          $display("FAIL response: got d_ready=%b if_ready=%b rdata=%h, want d_ready=%b if_ready=%b rdata=%h",
                   d_ready, if_ready, got, e.is_d, !e.is_d, e.rdata);
        end
      end
    end
    prev_req = mem_req;
  end
  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = if_ready || d_ready;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL timeout: no ready within 50 cycles");
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata, mem_be, mem_we, mem_req, if_ready, d_ready, arb_busy} !== '0) begin
      fails++;
      $display("FAIL reset_state: outputs not zero, mem_req=%b arb_busy=%b mem_addr=%h", mem_req, arb_busy, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_fetch();
    lat = 0;
    push(0, 32'h100, 1'b0, 4'hF, 32'h0);
    if_req = 1'b1;
    if_addr = 32'h100;
    @(negedge clk);
    tests++;
    if ({mem_req, mem_addr, mem_we, mem_be} !== {1'b1, 32'h100, 1'b0, 4'hF}) begin
      fails++;
      $display("FAIL fetch_req: got req=%b addr=%h we=%b be=%h, want 1 00000100 0 f", mem_req, mem_addr, mem_we, mem_be);
    end
    @(negedge clk);
    tests++;
    if ({if_ready, if_rdata} !== {1'b1, 32'h00500093}) begin
      fails++;
      $display("FAIL fetch_resp: got ready=%b rdata=%h, want 1 00500093", if_ready, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({if_ready, arb_busy, if_rdata} !== {1'b0, 1'b0, 32'h00500093}) begin
      fails++;
      $display("FAIL fetch_idle: got ready=%b busy=%b rdata=%h, want 0 0 00500093", if_ready, arb_busy, if_rdata);
    end
  endtask
  task automatic test_fetch_during_load();
    bit ok;
    lat = 2;
    push(1, 32'h300, 1'b0, 4'hF, 32'h0);
    push(0, 32'h104, 1'b0, 4'hF, 32'h0);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h300;
    d_wdata = 32'h0;
    d_be = 4'hF;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h104;
    wait_ready(ok);
    tests++;
    if ({d_ready, if_ready} !== 2'b10) begin
      fails++;
      $display("FAIL load_first: got d_ready=%b if_ready=%b, want 1 0", d_ready, if_ready);
    end
    d_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_req, arb_busy} !== 2'b00) begin
      fails++;
      $display("FAIL fetch_wait_idle: got mem_req=%b busy=%b, want 0 0", mem_req, arb_busy);
    end
    @(negedge clk);
    tests++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h104}) begin
      fails++;
      $display("FAIL fetch_after_load: got mem_req=%b addr=%h, want 1 00000104", mem_req, mem_addr);
    end
    wait_ready(ok);
    tests++;
    if (if_ready !== 1'b1) begin
      fails++;
      $display("FAIL fetch_done: got if_ready=%b, want 1", if_ready);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_store();
    lat = 3;
    push(1, 32'h200, 1'b1, 4'h3, 32'hDEADBEEF);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h200;
    d_wdata = 32'hDEADBEEF;
    d_be = 4'h3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_ready} !== {1'b1, 1'b1, 4'h3, 32'h200, 32'hDEADBEEF, 1'b0}) begin
        fails++;
        $display("FAIL store_hold[%0d]: got req=%b we=%b be=%h addr=%h wdata=%h d_ready=%b", k, mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_ready);
      end
    end
    @(negedge clk);
    tests++;
    if ({d_ready, d_rdata} !== {1'b1, d_model}) begin
      fails++;
      $display("FAIL store_resp: got d_ready=%b d_rdata=%h, want 1 %h", d_ready, d_rdata, d_model);
    end
    d_req = 1'b0;
    d_we = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    lat = 3;
    push(1, 32'h600, 1'b0, 4'hF, 32'h0);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h600;
    d_wdata = 32'h0;
    d_be = 4'hF;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata, mem_be, mem_we, mem_req, if_ready, d_ready, arb_busy} !== '0) begin
      fails++;
      $display("FAIL reset_mid: outputs not zero, mem_req=%b arb_busy=%b d_rdata=%h", mem_req, arb_busy, d_rdata);
    end
    exp_q.delete();
    d_model = '0;
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_en = 0;
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_en = 1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({if_ready, d_ready, arb_busy, mem_req, d_rdata} !== {4'b0, 32'h0}) begin
        fails++;
        $display("FAIL stray_ack_after_reset: got if=%b d=%b busy=%b req=%b d_rdata=%h", if_ready, d_ready, arb_busy, mem_req, d_rdata);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_idle_ack();
    mem_en = 0;
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_en = 1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({if_ready, d_ready, arb_busy, mem_req, if_rdata} !== {4'b0, 32'h0}) begin
        fails++;
        $display("FAIL idle_ack: got if=%b d=%b busy=%b req=%b if_rdata=%h", if_ready, d_ready, arb_busy, mem_req, if_rdata);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_back_to_back();
    int ni;
    int nr;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) push(0, 32'h500, 1'b0, 4'hF, 32'h0);
      else push(1, 32'h400, 1'b0, 4'hF, 32'h1234);
    end
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h400;
    d_wdata = 32'h1234;
    d_be = 4'hF;
    if_req = 1'b1;
    if_addr = 32'h500;
    ni = 0;
    nr = 0;
    for (int c = 0; c < 200 && nr < 10; c++) begin
      @(negedge clk);
      if (if_ready) ni++;
      if (if_ready || d_ready) nr++;
    end
    if_req = 1'b0;
    d_req = 1'b0;
    tests++;
    if (nr !== 10 || ni !== 2) begin
      fails++;
      $display("FAIL burst_count: got %0d readies with %0d fetches, want 10 with 2", nr, ni);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() !== 0 || arb_busy !== 1'b0) begin
      fails++;
      $display("FAIL burst_drain: got %0d pending busy=%b, want 0 0", exp_q.size(), arb_busy);
    end
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_fetch_during_load();
    test_store();
    test_reset_mid();
    test_idle_ack();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
